// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   size_e  : request size encoding (byte / half / word / illegal)
//   state_e : LSU control FSM states
//   LANE_*  : byte-lane and half-lane selectors within a 32-bit word
//   addr_misaligned() : size/alignment legality check on the low address bits
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_e;

    localparam logic [1:0] LANE_B0 = 2'd0;
    localparam logic [1:0] LANE_B1 = 2'd1;
    localparam logic [1:0] LANE_B2 = 2'd2;
    localparam logic [1:0] LANE_B3 = 2'd3;
    localparam logic       LANE_H0 = 1'b0;
    localparam logic       LANE_H1 = 1'b1;

    // Illegal size or an address that is not naturally aligned for the size.
    function automatic logic addr_misaligned(input size_e sz, input logic [1:0] lo);
        logic bad;
        case (sz)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lo[0];
            SZ_WORD: bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the LSU.
//   word    : memory word being read
//   size    : access size
//   lane    : byte address bits [1:0]
//   uns     : 1 = zero-extend loads, 0 = sign-extend
//   wdata   : right-aligned store data
//   ld_data : selected lane, extended to 32 bits
//   st_data : word with the addressed lane replaced by store data
//             (full wdata for word stores)
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  size_e       size,
    input  logic [1:0]  lane,
    input  logic        uns,
    input  logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic [31:0] st_data
);

    logic signed [7:0]  lane_b;
    logic signed [15:0] lane_h;

    always_comb begin
        lane_b = word[7:0];
        case (lane)
            LANE_B0: lane_b = word[7:0];
            LANE_B1: lane_b = word[15:8];
            LANE_B2: lane_b = word[23:16];
            LANE_B3: lane_b = word[31:24];
            default: lane_b = word[7:0];
        endcase
        lane_h = (lane[1] == LANE_H1) ? word[31:16] : word[15:0];

        ld_data = word;
        st_data = wdata;
        case (size)
            SZ_BYTE: begin
                ld_data = uns ? 32'(unsigned'(lane_b)) : 32'(lane_b);
                st_data = word;
                st_data[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                ld_data = uns ? 32'(unsigned'(lane_h)) : 32'(lane_h);
                st_data = word;
                st_data[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: begin
                ld_data = word;
                st_data = wdata;
            end
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit between a core request port and a word-addressed data memory.
// One request in flight; sub-word stores are done as read-modify-write.
//   clk, rst            : clock, asynchronous active-high reset
//   req_valid/req_ready : request handshake (ready only in IDLE)
//   req_we, req_size, req_unsigned, req_addr, req_wdata : request fields
//   resp_valid          : one-cycle completion pulse
//   resp_rdata          : extended load data (0 for stores and errors)
//   resp_err            : misaligned / illegal size / out-of-range
//   mem_we, mem_a, mem_wd : word write strobe, word index, write data
//   mem_rd              : combinational read data for mem_a
module lsu
    import lsu_pkg::*;
#(
    parameter int N = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    state_e      state_q;
    logic        we_q;
    size_e       size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        req_err;
    logic [31:0] ld_data;
    logic [31:0] st_data;

    assign req_ready = (state_q == IDLE);

    assign req_err = addr_misaligned(size_e'(req_size), req_addr[1:0])
                   || ({2'b00, req_addr[31:2]} >= 32'(N));

    // Fed straight from mem_rd: the word is captured at the end of RD into
    // either mem_wd (merged store word) or resp_rdata (extended load data).
    lsu_align u_align (
        .word    (mem_rd),
        .size    (size_q),
        .lane    (addr_q[1:0]),
        .uns     (uns_q),
        .wdata   (wdata_q),
        .ld_data (ld_data),
        .st_data (st_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            size_q     <= SZ_BYTE;
            uns_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_we     <= 1'b0;
            mem_a      <= '0;
            mem_wd     <= '0;
        end else begin
            // Outputs are registered and default to idle values each cycle;
            // each transition sets what the next state needs to present.
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_we     <= 1'b0;
            mem_a      <= '0;
            mem_wd     <= '0;

            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        size_q  <= size_e'(req_size);
                        uns_q   <= req_unsigned;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        if (req_err) begin
                            state_q    <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else if (req_we && (size_e'(req_size) == SZ_WORD)) begin
                            state_q <= WR;
                            mem_we  <= 1'b1;
                            mem_a   <= {2'b00, req_addr[31:2]};
                            mem_wd  <= req_wdata;
                        end else begin
                            state_q <= RD;
                            mem_a   <= {2'b00, req_addr[31:2]};
                        end
                    end
                end

                RD: begin
                    if (we_q) begin
                        state_q <= WR;
                        mem_we  <= 1'b1;
                        mem_a   <= {2'b00, addr_q[31:2]};
                        mem_wd  <= st_data;
                    end else begin
                        state_q    <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= ld_data;
                    end
                end

                WR: begin
                    state_q    <= RESP;
                    resp_valid <= 1'b1;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;
    import lsu_pkg::*;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [0:99];
    logic        pre_we;
    logic [6:0]  pre_a;
    logic [31:0] pre_d;

    lsu #(.N(100)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_we       (mem_we),
        .mem_a        (mem_a),
        .mem_wd       (mem_wd),
        .mem_rd       (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd = (mem_a < 32'd100) ? mem[mem_a[6:0]] : 32'h0;

    always @(posedge clk) begin
        if (pre_we) mem[pre_a] <= pre_d;
        else if (mem_we && mem_a < 32'd100) mem[mem_a[6:0]] <= mem_wd;
    end

    task automatic preload(input logic [6:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_a = a; pre_d = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    // Issue one request; k=1 is the cycle right after the accepting edge.
    task automatic run_req(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd,
                           output int lat, output logic [31:0] rdata, output logic err,
                           output logic [7:0] we_mask, output logic [31:0] wd_seen,
                           output logic vld_after);
        @(negedge clk);
        for (int g = 0; g < 20 && !req_ready; g++) @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = -1; rdata = 32'h0; err = 1'b0; we_mask = 8'h0; wd_seen = 32'h0;
        vld_after = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) begin
                @(posedge clk); #1;
            end
            if (mem_we) begin
                we_mask[k] = 1'b1;
                wd_seen = mem_wd;
            end
            if (resp_valid) begin
                lat = k; rdata = resp_rdata; err = resp_err;
                break;
            end
        end
        if (lat > 0) begin
            @(posedge clk); #1;
            vld_after = resp_valid;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err got=%b exp=0", resp_err); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", resp_rdata); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
        checks++; if (mem_a !== 32'h0) begin errors++; $display("FAIL reset_mem_a got=%h exp=0", mem_a); end
        checks++; if (mem_wd !== 32'h0) begin errors++; $display("FAIL reset_mem_wd got=%h exp=0", mem_wd); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_load();
        int lat; logic [31:0] rd; logic e; logic [7:0] wm; logic [31:0] wds; logic va;
        preload(7'd1, 32'h80FF_1234);
        run_req(1'b0, 2'b00, 1'b0, 32'h7, 32'h0, lat, rd, e, wm, wds, va);
        checks++; if (rd !== 32'hFFFF_FF80) begin errors++; $display("FAIL ldb_s_data got=%h exp=ffffff80", rd); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL ldb_s_lat got=%0d exp=2", lat); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL ldb_s_err got=%b exp=0", e); end
        checks++; if (va !== 1'b0) begin errors++; $display("FAIL ldb_s_pulse got=%b exp=0", va); end
        checks++; if (wm !== 8'h0) begin errors++; $display("FAIL ldb_s_we got=%h exp=00", wm); end
        run_req(1'b0, 2'b00, 1'b1, 32'h5, 32'h0, lat, rd, e, wm, wds, va);
        checks++; if (rd !== 32'h0000_0012) begin errors++; $display("FAIL ldb_u_data got=%h exp=00000012", rd); end
        run_req(1'b0, 2'b01, 1'b0, 32'h6, 32'h0, lat, rd, e, wm, wds, va);
        checks++; if (rd !== 32'hFFFF_80FF) begin errors++; $display("FAIL ldh_s_data got=%h exp=ffff80ff", rd); end
        run_req(1'b0, 2'b01, 1'b1, 32'h6, 32'h0, lat, rd, e, wm, wds, va);
        checks++; if (rd !== 32'h0000_80FF) begin errors++; $display("FAIL ldh_u_data got=%h exp=000080ff", rd); end
        run_req(1'b0, 2'b01, 1'b0, 32'h4, 32'h0, lat, rd, e, wm, wds, va);
        checks++; if (rd !== 32'h0000_1234) begin errors++; $display("FAIL ldh_lo_data got=%h exp=00001234", rd); end
        run_req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, lat, rd, e, wm, wds, va);
        checks++; if (rd !== 32'h80FF_1234) begin errors++; $display("FAIL ldw_data got=%h exp=80ff1234", rd); end
    endtask

    task automatic test_store_sub();
        int lat; logic [31:0] rd; logic e; logic [7:0] wm; logic [31:0] wds; logic va;
        preload(7'd1, 32'h1122_3344);
        run_req(1'b1, 2'b01, 1'b0, 32'h6, 32'h0000_BEEF, lat, rd, e, wm, wds, va);
        checks++; if (wds !== 32'hBEEF_3344) begin errors++; $display("FAIL sth_wd got=%h exp=beef3344", wds); end
        checks++; if (wm !== 8'b0000_0100) begin errors++; $display("FAIL sth_we_cycles got=%b exp=00000100", wm); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL sth_lat got=%0d exp=3", lat); end
        checks++; if (rd !== 32'h0 || e !== 1'b0) begin errors++; $display("FAIL sth_resp got=%h/%b exp=0/0", rd, e); end
        checks++; if (mem[1] !== 32'hBEEF_3344) begin errors++; $display("FAIL sth_mem got=%h exp=beef3344", mem[1]); end
        run_req(1'b1, 2'b00, 1'b0, 32'h5, 32'hFFFF_FFA5, lat, rd, e, wm, wds, va);
        checks++; if (mem[1] !== 32'hBEEF_A544) begin errors++; $display("FAIL stb_mem got=%h exp=beefa544", mem[1]); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL stb_lat got=%0d exp=3", lat); end
    endtask

    task automatic test_errors();
        int lat; logic [31:0] rd; logic e; logic [7:0] wm; logic [31:0] wds; logic va;
        run_req(1'b0, 2'b10, 1'b0, 32'h2, 32'h0, lat, rd, e, wm, wds, va);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_ldw_mis got=%b exp=1", e); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL err_ldw_lat got=%0d exp=1", lat); end
        checks++; if (wm !== 8'h0) begin errors++; $display("FAIL err_ldw_we got=%h exp=00", wm); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL err_ldw_rdata got=%h exp=0", rd); end
        run_req(1'b0, 2'b11, 1'b0, 32'h4, 32'h0, lat, rd, e, wm, wds, va);
        checks++; if (e !== 1'b1 || lat !== 1) begin errors++; $display("FAIL err_ill_size got=%b/%0d exp=1/1", e, lat); end
        run_req(1'b0, 2'b01, 1'b0, 32'h3, 32'h0, lat, rd, e, wm, wds, va);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_half_mis got=%b exp=1", e); end
        run_req(1'b1, 2'b10, 1'b0, 32'h5, 32'h1234_5678, lat, rd, e, wm, wds, va);
        checks++; if (e !== 1'b1 || wm !== 8'h0) begin errors++; $display("FAIL err_stw_mis got=%b/%h exp=1/00", e, wm); end
        checks++; if (mem[1] !== 32'hBEEF_A544) begin errors++; $display("FAIL err_stw_mem got=%h exp=beefa544", mem[1]); end
        run_req(1'b1, 2'b00, 1'b0, 32'h191, 32'h77, lat, rd, e, wm, wds, va);
        checks++; if (e !== 1'b1 || wm !== 8'h0) begin errors++; $display("FAIL err_stb_range got=%b/%h exp=1/00", e, wm); end
    endtask

    task automatic test_range();
        int lat; logic [31:0] rd; logic e; logic [7:0] wm; logic [31:0] wds; logic va;
        preload(7'd99, 32'hCAFE_F00D);
        run_req(1'b0, 2'b10, 1'b0, 32'h190, 32'h0, lat, rd, e, wm, wds, va);
        checks++; if (e !== 1'b1 || lat !== 1) begin errors++; $display("FAIL range_190 got=%b/%0d exp=1/1", e, lat); end
        run_req(1'b0, 2'b10, 1'b0, 32'h18C, 32'h0, lat, rd, e, wm, wds, va);
        checks++; if (e !== 1'b0 || lat !== 2) begin errors++; $display("FAIL range_18c_ctl got=%b/%0d exp=0/2", e, lat); end
        checks++; if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL range_18c_data got=%h exp=cafef00d", rd); end
    endtask

    task automatic test_reset_mid();
        preload(7'd2, 32'h5566_7788);
        @(negedge clk);
        for (int g = 0; g < 20 && !req_ready; g++) @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h8; req_wdata = 32'h99;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++; if (dut.state_q !== RD) begin errors++; $display("FAIL rstmid_in_rd got=%0d exp=%0d", dut.state_q, RD); end
        rst = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL rstmid_async got=%b/%b exp=1/0", req_ready, mem_we); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL rstmid_state got=%0d exp=%0d", dut.state_q, IDLE); end
        checks++; if (mem_we !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_after got=%b/%b exp=0/1", mem_we, req_ready); end
        @(posedge clk); #1;
        checks++; if (mem[2] !== 32'h5566_7788) begin errors++; $display("FAIL rstmid_mem got=%h exp=55667788", mem[2]); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] rd; logic e; logic [7:0] wm; logic [31:0] wds; logic va;
        run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, lat, rd, e, wm, wds, va);
        checks++; if (lat !== 2 || wm !== 8'b0000_0010) begin errors++; $display("FAIL b2b_stw got=%0d/%b exp=2/00000010", lat, wm); end
        checks++; if (wds !== 32'hDEAD_BEEF) begin errors++; $display("FAIL b2b_stw_wd got=%h exp=deadbeef", wds); end
        run_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, lat, rd, e, wm, wds, va);
        checks++; if (rd !== 32'h0000_00DE) begin errors++; $display("FAIL b2b_ldbu got=%h exp=000000de", rd); end
        checks++; if (lat !== 2 || e !== 1'b0) begin errors++; $display("FAIL b2b_ldbu_ctl got=%0d/%b exp=2/0", lat, e); end
    endtask

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        pre_we = 1'b0; pre_a = 7'd0; pre_d = 32'h0;
        test_reset();
        test_load();
        test_store_sub();
        test_errors();
        test_range();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter N, default 100, meaning number of 32-bit words in the attached data memory.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req_valid  input  1  core presents a load/store request.
REQ-005 SHALL have port req_ready  output  1  lsu can accept a request.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_size  input  2  00 byte, 01 half, 10 word; 11 is illegal.
REQ-008 SHALL have port req_unsigned  input  1  zero-extend load result when 1, sign-extend when 0.
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 SHALL have port resp_err  output  1  misaligned, illegal size or out-of-range; qualified by resp_valid.
REQ-014 SHALL have port mem_we  output  1  active-high word write strobe to data memory.
REQ-015 SHALL have port mem_a  output  32  word index (byte address >> 2).
REQ-016 SHALL have port mem_wd  output  32  word write data.
REQ-017 SHALL have port mem_rd  input  32  combinational read data for mem_a.

Function
REQ-018 SHALL implement FSM states IDLE, RD, WR, RESP; req_ready = 1 only in IDLE.
REQ-019 SHALL latch req_* on the cycle req_valid && req_ready is true (cycle 0).
REQ-020 SHALL flag an error when req_size = 11, half address bit0 = 1, word address bits[1:0] != 0, or req_addr[31:2] >= N.
REQ-021 SHALL use these transitions: error IDLE->RESP; load IDLE->RD->RESP; word store IDLE->WR->RESP; byte/half store IDLE->RD->WR->RESP; RESP->IDLE always.
REQ-022 SHALL never assert mem_we for an erroneous request.
REQ-023 SHALL drive mem_a with the latched word index in RD and WR, and 0 otherwise.
REQ-024 SHALL capture mem_rd into a word register at the end of RD.
REQ-025 SHALL assert mem_we only in WR; mem_wd = req_wdata for word stores, otherwise the captured word with the addressed byte/half lane replaced by the low bits of req_wdata.
REQ-026 SHALL assert resp_valid for exactly the single RESP cycle, with resp_rdata/resp_err stable during it.
REQ-027 SHALL produce resp_rdata for loads as the addressed lane (lane = addr[1:0] for bytes, addr[1] for halves) of the captured word, extended per req_unsigned.
REQ-028 SHALL have the following latencies from accept: load 2 cycles, word store 2, sub-word store 3, error 1.
REQ-029 SHALL ignore req_valid outside IDLE; no request queuing, no response backpressure.

Reset
REQ-030 SHALL on rst force state IDLE, and drive req_ready = 1 and resp_valid, resp_err, resp_rdata, mem_we, mem_a, mem_wd = 0.
REQ-031 SHALL abandon any in-flight request when rst is asserted mid-operation, including in RD of a read-modify-write, so no partial write occurs.

Structure
REQ-032 SHALL place the size encoding enum, the FSM state enum and lane constants in shared package lsu_pkg.
REQ-033 SHALL implement lane extraction/extension and store merging in one combinational sub-module lsu_align.

Verification
REQ-034 SHALL cover: word[1] = 0x80FF_1234, signed byte load at 0x7 -> resp_rdata 0xFFFF_FF80, resp_valid 2 cycles after accept.
REQ-035 SHALL cover: word[1] = 0x1122_3344, half store 0xBEEF at 0x6 -> RD then WR, mem_wd 0xBEEF_3344, resp_valid 3 cycles after accept.
REQ-036 SHALL cover: word load at 0x2 -> resp_err = 1 after 1 cycle, mem_we never asserted.
REQ-037 SHALL cover: N = 100, word load at 0x190 -> resp_err = 1; at 0x18C -> normal read of word[99].
REQ-038 SHALL cover: rst asserted during RD of a byte store -> mem_we stays 0, state IDLE, req_ready = 1 next cycle.
REQ-039 SHALL cover: back-to-back word store 0xDEAD_BEEF at 0x10 then unsigned byte load at 0x13 -> resp_rdata 0x0000_00DE.
